// File: rtl/systolic_operand_feeder.sv
// rtl/systolic_operand_feeder.sv - buffers A/B and streams them diagonally skewed into a DIMxDIM systolic array
// Optional macro FEEDER_WR_ERR_EN: sticky wr_err_o for writes attempted while busy.
module systolic_operand_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic                          wr_sel_i,
    input  logic [$clog2(DIM*DIM)-1:0]    wr_addr_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          go_i,
    input  logic                          release_i,
    output logic [DIM*DATA_WIDTH-1:0]     a_row_o,
    output logic [DIM*DATA_WIDTH-1:0]     b_col_o,
    output logic                          start_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          wr_err_o
);
    localparam int N      = DIM * DIM;
    localparam int AW     = $clog2(N);
    localparam int T_LAST = 3 * DIM - 3;
    localparam int TW     = $clog2(3 * DIM);

    typedef enum logic [1:0] {IDLE, FEED, HOLD} state_t;

    state_t                      state;
    logic [TW-1:0]               t;
    logic [TW-1:0]               ft;
    logic                        wr_ok;
    logic [DATA_WIDTH-1:0]       a_buf [N];
    logic [DATA_WIDTH-1:0]       b_buf [N];
    logic [DATA_WIDTH-1:0]       a_view [N];
    logic [DATA_WIDTH-1:0]       b_view [N];
    logic [DIM*DATA_WIDTH-1:0]   a_lanes;
    logic [DIM*DATA_WIDTH-1:0]   b_lanes;

    assign wr_ok = wr_en_i && (state == IDLE);

    // The view forwards an IDLE write so a write coinciding with go is already seen by feed cycle 0.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_view[i] = a_buf[i];
            b_view[i] = b_buf[i];
            if (wr_ok && wr_addr_i == AW'(i)) begin
                if (wr_sel_i)
                    b_view[i] = wr_data_i;
                else
                    a_view[i] = wr_data_i;
            end
        end
        ft      = (state == IDLE) ? '0 : t + 1'b1;
        a_lanes = '0;
        b_lanes = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) begin
                if (int'(ft) == r + k) begin
                    a_lanes[r*DATA_WIDTH +: DATA_WIDTH] = a_view[r*DIM + k];
                    b_lanes[r*DATA_WIDTH +: DATA_WIDTH] = b_view[k*DIM + r];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                a_buf[i] <= '0;
                b_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                a_buf[i] <= a_view[i];
                b_buf[i] <= b_view[i];
            end
        end
    end

    // Outputs are loaded with the lanes of the cycle being entered, so they stay registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            t       <= '0;
            a_row_o <= '0;
            b_col_o <= '0;
            start_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_i) begin
                        state   <= FEED;
                        t       <= '0;
                        a_row_o <= a_lanes;
                        b_col_o <= b_lanes;
                        start_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                FEED: begin
                    if (t == TW'(T_LAST)) begin
                        state   <= HOLD;
                        a_row_o <= '0;
                        b_col_o <= '0;
                        done_o  <= 1'b1;
                    end else begin
                        t       <= t + 1'b1;
                        a_row_o <= a_lanes;
                        b_col_o <= b_lanes;
                    end
                end
                HOLD: begin
                    if (release_i) begin
                        state   <= IDLE;
                        start_o <= 1'b0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FEEDER_WR_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            wr_err_o <= 1'b0;
        else if (state == IDLE && go_i)
            wr_err_o <= 1'b0;
        else if (wr_en_i && busy_o)
            wr_err_o <= 1'b1;
    end
`else
    assign wr_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// tb/tb_systolic_operand_feeder.sv - scoreboard bench for systolic_operand_feeder with a reference PE array
module tb_systolic_operand_feeder;
    localparam int DW  = 32;
    localparam int DIM = 2;
    localparam int N   = DIM * DIM;
    localparam int AW  = $clog2(N);
    localparam int T   = 3 * DIM - 2;

    logic              clk = 1'b0;
    logic              rst, wr_en, wr_sel, go, rel;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [DIM*DW-1:0] a_row, b_col;
    logic              start, busy, done, wr_err;

    systolic_operand_feeder #(.DATA_WIDTH(DW), .DIM(DIM)) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .go_i(go), .release_i(rel),
        .a_row_o(a_row), .b_col_o(b_col), .start_o(start), .busy_o(busy),
        .done_o(done), .wr_err_o(wr_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DIM*DW-1:0] a;
        logic [DIM*DW-1:0] b;
        logic [2:0]        ctl;
    } exp_t;

    exp_t        sb[$];
    logic [DW-1:0] ma[N];
    logic [DW-1:0] mb[N];
    logic          exp_err;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference output-stationary PE array fed by the DUT.
    logic [DW-1:0] pa[DIM][DIM];
    logic [DW-1:0] pb[DIM][DIM];
    logic [DW-1:0] acc[DIM][DIM];

    function automatic logic [DW-1:0] a_in(input int i, input int j);
        if (j == 0) return a_row[i*DW +: DW];
        return pa[i][j-1];
    endfunction

    function automatic logic [DW-1:0] b_in(input int i, input int j);
        if (i == 0) return b_col[j*DW +: DW];
        return pb[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                pa[i][j]  <= a_in(i, j);
                pb[i][j]  <= b_in(i, j);
                acc[i][j] <= start ? acc[i][j] + a_in(i, j) * b_in(i, j) : '0;
            end
        end
    end

    function automatic logic [DW-1:0] c_ref(input int i, input int j);
        logic [DW-1:0] s = '0;
        for (int k = 0; k < DIM; k++) s = s + ma[i*DIM + k] * mb[k*DIM + j];
        return s;
    endfunction

    task automatic push_run();
        exp_t e;
        for (int t = 0; t < T; t++) begin
            e.a = '0;
            e.b = '0;
            for (int r = 0; r < DIM; r++) begin
                if (t - r >= 0 && t - r < DIM) begin
                    e.a[r*DW +: DW] = ma[r*DIM + (t - r)];
                    e.b[r*DW +: DW] = mb[(t - r)*DIM + r];
                end
            end
            e.ctl = 3'b110;
            sb.push_back(e);
        end
        e.a   = '0;
        e.b   = '0;
        e.ctl = 3'b111;
        sb.push_back(e);
    endtask

    task automatic compare_next(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_underflow"}, 256'd1, 256'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_a"}, 256'(a_row), 256'(e.a));
            check({tag, "_b"}, 256'(b_col), 256'(e.b));
            check({tag, "_ctl"}, 256'({start, busy, done}), 256'(e.ctl));
        end
    endtask

    task automatic wr(input logic sel, input int addr, input logic [DW-1:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
        if (sel) mb[addr] = data; else ma[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_c(input string tag);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), 256'(acc[i][j]), 256'(c_ref(i, j)));
    endtask

    // race: write A[0]=9 alongside go; disturb: write B[3], go and release during FEED.
    task automatic run(input string tag, input bit race, input bit disturb);
        if (race) ma[0] = 32'd9;
        push_run();
        @(negedge clk);
        go = 1'b1;
        if (race) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 32'd9;
        end
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
        for (int t = 0; t < T; t++) begin
            compare_next($sformatf("%s_t%0d", tag, t));
            if (disturb && t == 1) begin
                wr_en = 1'b1; wr_sel = 1'b1; wr_addr = AW'(3); wr_data = 32'd100;
                go = 1'b1; rel = 1'b1;
            end
            @(negedge clk);
            wr_en = 1'b0; go = 1'b0; rel = 1'b0;
        end
        compare_next({tag, "_hold"});
        check_c(tag);
        check({tag, "_wr_err"}, 256'(wr_err), 256'(exp_err));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("%s_hold%0d", tag, k), 256'({start, busy, done}), 256'(3'b111));
        end
        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
        check({tag, "_released"}, 256'({start, busy, done}), 256'(3'b000));
        @(negedge clk);
        check({tag, "_acc_clear"}, 256'(acc[DIM-1][DIM-1]), 256'd0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        go = 1'b0; rel = 1'b0; exp_err = 1'b0;
        for (int i = 0; i < N; i++) begin ma[i] = '0; mb[i] = '0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_out", 256'({a_row, b_col, start, busy, done, wr_err}), 256'd0);

        for (int i = 0; i < N; i++) begin
            wr(1'b0, i, DW'(i + 1));
            wr(1'b1, i, DW'(i + 5));
        end
        run("base", 1'b0, 1'b0);

`ifdef FEEDER_WR_ERR_EN
        exp_err = 1'b1;
`endif
        run("race", 1'b1, 1'b1);
        exp_err = 1'b0;
        run("rerun", 1'b0, 1'b0);

        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_feed_out", 256'({a_row, b_col, start, busy, done, wr_err}), 256'd0);
        @(negedge clk);
        check("rst_feed_idle", 256'({start, busy, done}), 256'd0);

        for (int i = 0; i < N; i++) begin ma[i] = '0; mb[i] = '0; end
        wr(1'b0, 0, 32'd2); wr(1'b0, 1, -32'sd1); wr(1'b0, 3, 32'd3);
        wr(1'b1, 0, 32'd4); wr(1'b1, 1, 32'd7); wr(1'b1, 2, -32'sd2);
        run("reload", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
